// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-read-port register file.
// The master side is decode/writeback.
// The slave side is the register file itself.
// The parameters must match the ones given to regfile_mp.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) ();

  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ-1:0]            read_busy;
  logic [ADDR_WIDTH-1:0]          write_reg;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           reg_write;
  logic                           mark_valid;
  logic [ADDR_WIDTH-1:0]          mark_reg;
  logic                           init_done;
  logic [DATA_WIDTH-1:0]          sys_call_reg;
  logic [DATA_WIDTH-1:0]          std_out_address;

  modport master (
    output read_reg, write_reg, write_data, reg_write, mark_valid, mark_reg,
    input  read_data, read_busy, init_done, sys_call_reg, std_out_address
  );

  modport slave (
    input  read_reg, write_reg, write_data, reg_write, mark_valid, mark_reg,
    output read_data, read_busy, init_done, sys_call_reg, std_out_address
  );

endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file for the MIPS datapath.
// - After reset, a hardware sweep zeroes one entry per cycle before normal operation.
// - Reads are registered on posedge, with optional write-to-read forwarding.
// - Register 0 can be hardwired to zero.
// - A per-register busy scoreboard tracks registers claimed by in-flight producers.
// - The $v0/$a0 taps feed the syscall unit.
// ADDR_WIDTH must be at least 3 so that registers 2 and 4 exist.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] SYS_IDX = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OUT_IDX = ADDR_WIDTH'(4);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [ADDR_WIDTH-1:0]   sweep_cnt_r;
  logic                    sweep_last_s;
  logic [DATA_WIDTH-1:0]   regs_r [DEPTH];
  logic [DEPTH-1:0]        busy_r;
  logic [DEPTH-1:0]        busy_nxt_s;
  logic                    wr_en_s;
  logic                    mark_en_s;
  logic [DATA_WIDTH-1:0]   rd_data_r     [NUM_READ];
  logic [DATA_WIDTH-1:0]   rd_data_nxt_s [NUM_READ];
  logic [NUM_READ-1:0]     rd_busy_r;
  logic [NUM_READ-1:0]     rd_busy_nxt_s;
  logic                    init_done_r;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data_s;

  // True when the address names the hardwired-zero register
  function automatic logic is_zero_addr(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_WIDTH{1'b0}});
  endfunction

  assign sweep_last_s = (sweep_cnt_r == {ADDR_WIDTH{1'b1}});

  // Writes and marks only take effect in RUN, and never on the zero register
  assign wr_en_s   = (state_r == ST_RUN) && bus.reg_write  && !is_zero_addr(bus.write_reg);
  assign mark_en_s = (state_r == ST_RUN) && bus.mark_valid && !is_zero_addr(bus.mark_reg);

  // State register: reset always restarts the zeroing sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave INIT once the last entry has been zeroed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (sweep_last_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Sweep counter: walks every address once while in INIT
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else if (state_r == ST_INIT) begin
      sweep_cnt_r <= sweep_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      sweep_cnt_r <= sweep_cnt_r;
    end
  end

  // Storage array.
  // In INIT, the sweep zeroes one entry per cycle.
  // In RUN, the array takes writeback data.
  // The array has no reset of its own; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_r == ST_INIT) begin
        regs_r[sweep_cnt_r] <= {DATA_WIDTH{1'b0}};
      end else if (wr_en_s) begin
        regs_r[bus.write_reg] <= bus.write_data;
      end
    end
  end

  // Scoreboard update.
  // A write clears busy, then a mark sets it.
  // So a producer claiming the register in the same cycle wins.
  always_comb begin
    busy_nxt_s = busy_r;
    if (wr_en_s) begin
      busy_nxt_s[bus.write_reg] = 1'b0;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
    if (mark_en_s) begin
      busy_nxt_s[bus.mark_reg] = 1'b1;
    end else begin
      busy_nxt_s = busy_nxt_s;
    end
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read-port next values.
  // Priority order: zero register, then write bypass, then stored value.
  // Without bypass, the pre-edge data and busy bit are returned.
  always_comb begin
    logic [ADDR_WIDTH-1:0] addr_v;
    logic                  mark_hit_v;
    addr_v        = {ADDR_WIDTH{1'b0}};
    mark_hit_v    = 1'b0;
    rd_busy_nxt_s = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      rd_data_nxt_s[i] = {DATA_WIDTH{1'b0}};
      addr_v     = bus.read_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
      mark_hit_v = mark_en_s && (bus.mark_reg == addr_v);
      if (state_r != ST_RUN) begin
        rd_data_nxt_s[i] = {DATA_WIDTH{1'b0}};
        rd_busy_nxt_s[i] = 1'b0;
      end else if (is_zero_addr(addr_v)) begin
        rd_data_nxt_s[i] = {DATA_WIDTH{1'b0}};
        rd_busy_nxt_s[i] = 1'b0;
      end else if ((BYPASS != 0) && wr_en_s && (bus.write_reg == addr_v)) begin
        rd_data_nxt_s[i] = bus.write_data;
        rd_busy_nxt_s[i] = mark_hit_v;
      end else if (BYPASS != 0) begin
        rd_data_nxt_s[i] = regs_r[addr_v];
        rd_busy_nxt_s[i] = busy_r[addr_v] | mark_hit_v;
      end else begin
        rd_data_nxt_s[i] = regs_r[addr_v];
        rd_busy_nxt_s[i] = busy_r[addr_v];
      end
    end
  end

  // Registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_READ; i++) begin
        rd_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
      rd_busy_r <= {NUM_READ{1'b0}};
    end else begin
      for (int i = 0; i < NUM_READ; i++) begin
        rd_data_r[i] <= rd_data_nxt_s[i];
      end
      rd_busy_r <= rd_busy_nxt_s;
    end
  end

  // init_done rises one cycle after the FSM enters RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= (state_r == ST_RUN);
    end
  end

  // Pack per-port read registers onto the flat output bus
  always_comb begin
    read_data_s = {(NUM_READ*DATA_WIDTH){1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      read_data_s[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_r[i];
    end
  end

  assign bus.read_data = read_data_s;
  assign bus.read_busy = rd_busy_r;
  assign bus.init_done = init_done_r;

  // The syscall taps read the array directly.
  // They are masked during the sweep, so stale pre-reset contents never leak out.
  assign bus.sys_call_reg    = (state_r == ST_RUN) ? regs_r[SYS_IDX] : {DATA_WIDTH{1'b0}};
  assign bus.std_out_address = (state_r == ST_RUN) ? regs_r[OUT_IDX] : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the MIPS CPU datapath, replacing the fixed 2-read/32x32 register file. Adds synchronous reset with a hardware zero-initialisation sweep, single-edge (posedge) registered reads with optional write-to-read bypass, hardwired-zero register 0, and a per-register busy scoreboard for multi-cycle producers. It sits between decode (read addresses, scoreboard marks) and writeback (write port), and keeps the syscall taps ($v0, $a0) used by the syscall unit.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries
- NUM_READ, 2, number of read ports (>= 1)
- BYPASS, 1, 1 = same-cycle write is forwarded to reads of the same address; 0 = read returns pre-write value
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and marks

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- read_reg  in  NUM_READ*ADDR_WIDTH  read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  out  NUM_READ*DATA_WIDTH  registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
- read_busy  out  NUM_READ  registered busy flag for each port's address
- write_reg  in  ADDR_WIDTH  write address
- write_data  in  DATA_WIDTH  write data
- reg_write  in  1  write enable
- mark_valid  in  1  set busy bit of mark_reg
- mark_reg  in  ADDR_WIDTH  register being claimed by an in-flight producer
- init_done  out  1  high once zero sweep complete
- sys_call_reg  out  DATA_WIDTH  contents of register 2
- std_out_address  out  DATA_WIDTH  contents of register 4

## Operation
- States: INIT, RUN. Reset (any cycle, any state) -> INIT, sweep counter = 0, all busy bits cleared, read_data = 0, read_busy = 0, init_done = 0.
- INIT: one entry per cycle written with 0 at address = counter; counter increments; after writing entry DEPTH-1 -> RUN, init_done = 1 from the next cycle. reg_write and mark_valid ignored; read_data/read_busy held 0.
- RUN write: reg_write=1 stores write_data at write_reg on posedge; also clears busy[write_reg]. With ZERO_REG=1 and write_reg=0, no effect.
- RUN mark: mark_valid=1 sets busy[mark_reg]. Mark and write to same register in same cycle: busy ends set (new producer wins), data still written. Mark on reg 0 ignored when ZERO_REG=1.
- RUN read, per port i, registered on posedge: if ZERO_REG and addr=0 -> data 0, busy 0. Else if BYPASS and reg_write and write_reg=addr -> data=write_data, busy = (mark_valid and mark_reg=addr). Else data = stored value, busy = busy[addr] | (mark_valid and mark_reg=addr) with write clearing applied as above when BYPASS=1; when BYPASS=0, busy = pre-edge busy[addr].
- All read ports independent; any number may address the same register.
- Taps sys_call_reg/std_out_address: combinational from array; reflect writes committed at prior edges; 0 during/after INIT until written.

## Timing
- Read latency 1 cycle: address at edge N -> data valid after edge N (visible cycle N+1).
- Write visible via array read at edge N+1; via bypass at edge N (BYPASS=1).
- Reset to init_done: DEPTH+1 edges after reset deasserts-sampled edge (DEPTH sweep writes, then flag).
- Reset asserted mid-sweep restarts sweep at 0.
- No backpressure; every enabled write and mark in RUN is accepted that cycle.

## Test plan
- Reset 1 cycle, hold 0 -> init_done low for 32 cycles, high on 33rd; all 32 registers read 0; read_data 0 throughout INIT; write to reg 5 during INIT discarded (reads 0 after).
- RUN: write reg 8 = 0x0000_0004, next cycle read port0=8, port1=8 -> both return 4 one cycle later; write reg 0 = 0xFFFF_FFFF -> reads 0.
- Same-cycle write reg 3 = 0xDEAD_BEEF and read port1=3: BYPASS=1 -> 0xDEADBEEF; BYPASS=0 -> prior value.
- mark reg 9, read 9 next cycle -> read_busy=1; write reg 9 -> busy clears, same-cycle read with BYPASS=1 shows busy 0 and new data; simultaneous mark+write reg 9 -> busy stays 1.
- Write reg 2 = 10, reg 4 = 0x1000 -> sys_call_reg=10, std_out_address=0x1000 after the write edge; NUM_READ=4, DATA_WIDTH=64 instance passes same checks per port.
- Reset asserted at sweep count 10 -> counter restarts, init_done after full 33 cycles; busy bits and previously written registers cleared.
